// File: rtl/mem_stage_if.sv
// Bundle of the stage's execute-side, data-cache and writeback-side signals.
// slave is the memory stage; master is whatever surrounds it.
interface mem_stage_if;
    // execute -> memory FIFO head
    logic        EXE2MEM_EMPTY_SE;
    logic        EXE2MEM_POP_SM;
    logic [31:0] RES_RE;
    logic [31:0] MEM_DATA_RE;
    logic [5:0]  DEST_RE;
    logic [1:0]  MEM_SIZE_RE;
    logic        MEM_SIGN_EXTEND_RE;
    logic        MEM_LOAD_RE;
    logic        MEM_STORE_RE;
    logic        WB_RE;
    logic        EXCEPTION_RE;
    // data cache
    logic [31:0] MCACHE_ADR_SM;
    logic [31:0] MCACHE_DATA_SM;
    logic [3:0]  MCACHE_BYTE_SEL_SM;
    logic        MCACHE_ADR_VALID_SM;
    logic        MCACHE_STORE_SM;
    logic        MCACHE_LOAD_SM;
    logic        MCACHE_STALL_SC;
    logic [31:0] MCACHE_RESULT_SC;
    // memory -> writeback FIFO head
    logic        MEM2WBK_POP_SW;
    logic        MEM2WBK_EMPTY_SM;
    logic [31:0] MEM_RES_RM;
    logic [5:0]  MEM_DEST_RM;
    logic        MEM_WB_RM;
    logic        EXCEPTION_RM;

    modport slave (
        input  EXE2MEM_EMPTY_SE, RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE,
               MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, WB_RE, EXCEPTION_RE,
               MCACHE_STALL_SC, MCACHE_RESULT_SC, MEM2WBK_POP_SW,
        output EXE2MEM_POP_SM, MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_BYTE_SEL_SM,
               MCACHE_ADR_VALID_SM, MCACHE_STORE_SM, MCACHE_LOAD_SM,
               MEM2WBK_EMPTY_SM, MEM_RES_RM, MEM_DEST_RM, MEM_WB_RM, EXCEPTION_RM
    );

    modport master (
        output EXE2MEM_EMPTY_SE, RES_RE, MEM_DATA_RE, DEST_RE, MEM_SIZE_RE,
               MEM_SIGN_EXTEND_RE, MEM_LOAD_RE, MEM_STORE_RE, WB_RE, EXCEPTION_RE,
               MCACHE_STALL_SC, MCACHE_RESULT_SC, MEM2WBK_POP_SW,
        input  EXE2MEM_POP_SM, MCACHE_ADR_SM, MCACHE_DATA_SM, MCACHE_BYTE_SEL_SM,
               MCACHE_ADR_VALID_SM, MCACHE_STORE_SM, MCACHE_LOAD_SM,
               MEM2WBK_EMPTY_SM, MEM_RES_RM, MEM_DEST_RM, MEM_WB_RM, EXCEPTION_RM
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: forwards ALU results, runs loads/stores against the
// data cache, and queues results in a small mem->writeback FIFO whose head is also
// the bypass source for execute.
module mem_stage #(
    parameter int unsigned DEPTH = 2
) (
    input logic        clk,
    input logic        reset,
    mem_stage_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

    typedef enum logic [0:0] {StIdle, StReq} state_e;
    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  dest;
        logic        wb;
        logic        exc;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     adr_q, adr_d, wdata_q, wdata_d;
    logic [3:0]      bsel_q, bsel_d;
    logic            valid_q, valid_d, store_q, store_d, load_q, load_d;
    entry_t          fifo_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]   count_q, count_d;

    logic        full, empty, mem_op, push, pop_exe, pop_wbk;
    entry_t      push_entry, head;
    logic [1:0]  off;
    logic [3:0]  byte_sel;
    logic [31:0] store_data, load_res;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign off    = bus.RES_RE[1:0];
    assign mem_op = (bus.MEM_LOAD_RE | bus.MEM_STORE_RE) & ~bus.EXCEPTION_RE;
    assign empty  = (count_q == '0);
    assign full   = (count_q == DepthCnt);

    // Store-side lane replication and byte enables from size and offset.
    always_comb begin
        case (bus.MEM_SIZE_RE)
            2'b01: begin
                byte_sel   = 4'b0011 << off;
                store_data = {2{bus.MEM_DATA_RE[15:0]}};
            end
            2'b10: begin
                byte_sel   = 4'b0001 << off;
                store_data = {4{bus.MEM_DATA_RE[7:0]}};
            end
            default: begin
                byte_sel   = 4'b1111;
                store_data = bus.MEM_DATA_RE;
            end
        endcase
    end

    // Load-side lane extraction and sign/zero extension of the returned cache word.
    always_comb begin
        case (off)
            2'd0:    byte_lane = bus.MCACHE_RESULT_SC[7:0];
            2'd1:    byte_lane = bus.MCACHE_RESULT_SC[15:8];
            2'd2:    byte_lane = bus.MCACHE_RESULT_SC[23:16];
            default: byte_lane = bus.MCACHE_RESULT_SC[31:24];
        endcase
        half_lane = off[1] ? bus.MCACHE_RESULT_SC[31:16] : bus.MCACHE_RESULT_SC[15:0];
        case (bus.MEM_SIZE_RE)
            2'b01:   load_res = {{16{bus.MEM_SIGN_EXTEND_RE & half_lane[15]}}, half_lane};
            2'b10:   load_res = {{24{bus.MEM_SIGN_EXTEND_RE & byte_lane[7]}}, byte_lane};
            default: load_res = bus.MCACHE_RESULT_SC;
        endcase
    end

    // FSM next state, registered cache request, and execute pop / FIFO push decisions.
    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        wdata_d    = wdata_q;
        bsel_d     = bsel_q;
        valid_d    = valid_q;
        store_d    = store_q;
        load_d     = load_q;
        pop_exe    = 1'b0;
        push       = 1'b0;
        // Exceptions never write back.
        push_entry = '{res: bus.RES_RE, dest: bus.DEST_RE,
                       wb: bus.WB_RE & ~bus.EXCEPTION_RE, exc: bus.EXCEPTION_RE};
        unique case (state_q)
            StIdle: begin
                // Entering REQ only when not full reserves the slot for its later push.
                if (!bus.EXE2MEM_EMPTY_SE && !full) begin
                    if (mem_op) begin
                        state_d = StReq;
                        adr_d   = {bus.RES_RE[31:2], 2'b00};
                        wdata_d = store_data;
                        bsel_d  = byte_sel;
                        valid_d = 1'b1;
                        store_d = bus.MEM_STORE_RE;
                        load_d  = bus.MEM_LOAD_RE & ~bus.MEM_STORE_RE;
                    end else begin
                        pop_exe = 1'b1;
                        push    = 1'b1;
                    end
                end
            end
            StReq: begin
                if (!bus.MCACHE_STALL_SC) begin
                    pop_exe        = 1'b1;
                    push           = 1'b1;
                    push_entry.exc = 1'b0;
                    if (store_q) begin
                        push_entry.wb = 1'b0;
                    end else begin
                        push_entry.res = load_res;
                        push_entry.wb  = bus.WB_RE;
                    end
                    state_d = StIdle;
                    adr_d   = '0;
                    wdata_d = '0;
                    bsel_d  = '0;
                    valid_d = 1'b0;
                    store_d = 1'b0;
                    load_d  = 1'b0;
                end
            end
        endcase
        if (reset || bus.EXE2MEM_EMPTY_SE) begin
            pop_exe = 1'b0;
            push    = 1'b0;
        end
    end

    // FIFO pointer and occupancy bookkeeping; pops on an empty FIFO are dropped.
    always_comb begin
        pop_wbk  = bus.MEM2WBK_POP_SW & ~empty;
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop_wbk ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        case ({push, pop_wbk})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // State, request registers and FIFO pointers; reset drops any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            adr_q    <= '0;
            wdata_q  <= '0;
            bsel_q   <= '0;
            valid_q  <= 1'b0;
            store_q  <= 1'b0;
            load_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            bsel_q   <= bsel_d;
            valid_q  <= valid_d;
            store_q  <= store_d;
            load_q   <= load_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observable while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head = empty ? '0 : fifo_q[rd_ptr_q];

    assign bus.EXE2MEM_POP_SM      = pop_exe;
    assign bus.MCACHE_ADR_SM       = adr_q;
    assign bus.MCACHE_DATA_SM      = wdata_q;
    assign bus.MCACHE_BYTE_SEL_SM  = bsel_q;
    assign bus.MCACHE_ADR_VALID_SM = valid_q;
    assign bus.MCACHE_STORE_SM     = store_q;
    assign bus.MCACHE_LOAD_SM      = load_q;
    assign bus.MEM2WBK_EMPTY_SM    = empty;
    assign bus.MEM_RES_RM          = head.res;
    assign bus.MEM_DEST_RM         = head.dest;
    assign bus.MEM_WB_RM           = head.wb;
    assign bus.EXCEPTION_RM        = head.exc;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table of single execute entries with hand-computed
// cache requests and results, a scoreboard checked as writeback drains the FIFO,
// plus sequences for FIFO back-pressure/wrap and reset during a stalled request.
module tb_mem_stage;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mem_stage_if bus ();

    mem_stage #(.DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  dest;
        logic        wb;
        logic        exc;
    } sb_t;

    typedef struct {
        logic [31:0] res;
        logic [31:0] data;
        logic [5:0]  dest;
        logic [1:0]  size;
        logic        sext;
        logic        load;
        logic        store;
        logic        wb;
        logic        exc;
        logic [31:0] cache;
        int          stalls;
        logic        acc;       // expected to reach the cache
        logic [31:0] exp_adr;
        logic [3:0]  exp_bsel;
        logic [31:0] exp_sdata; // checked for stores only
        logic [31:0] exp_res;
        logic        exp_wb;
        logic        exp_exc;
    } vec_t;

    sb_t  sb [$];
    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Writeback consumer: whenever it pops a non-empty FIFO, the head must match.
    always @(negedge clk) begin
        #2;
        if (bus.MEM2WBK_POP_SW === 1'b1 && bus.MEM2WBK_EMPTY_SM === 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got res 0x%08h expected no entry", bus.MEM_RES_RM);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("wb_res", bus.MEM_RES_RM, e.res);
                chk("wb_dest", 32'(bus.MEM_DEST_RM), 32'(e.dest));
                chk("wb_wb", 32'(bus.MEM_WB_RM), 32'(e.wb));
                chk("wb_exc", 32'(bus.EXCEPTION_RM), 32'(e.exc));
            end
        end
    end

    task automatic drive(input vec_t v);
        bus.RES_RE             = v.res;
        bus.MEM_DATA_RE        = v.data;
        bus.DEST_RE            = v.dest;
        bus.MEM_SIZE_RE        = v.size;
        bus.MEM_SIGN_EXTEND_RE = v.sext;
        bus.MEM_LOAD_RE        = v.load;
        bus.MEM_STORE_RE       = v.store;
        bus.WB_RE              = v.wb;
        bus.EXCEPTION_RE       = v.exc;
        bus.MCACHE_RESULT_SC   = v.cache;
        bus.MCACHE_STALL_SC    = (v.stalls != 0);
        bus.EXE2MEM_EMPTY_SE   = 1'b0;
        sb.push_back('{v.exp_res, v.dest, v.exp_wb, v.exp_exc});
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        drive(v);
        #1;
        if (!v.acc) begin
            chk({tag, "_alu_pop"}, 32'(bus.EXE2MEM_POP_SM), 32'd1);
            chk({tag, "_no_req"}, 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
        end else begin
            chk({tag, "_idle_nopop"}, 32'(bus.EXE2MEM_POP_SM), 32'd0);
            for (int c = 0; c <= v.stalls; c++) begin
                @(negedge clk);
                if (c == v.stalls) bus.MCACHE_STALL_SC = 1'b0;
                #1;
                chk({tag, "_valid"}, 32'(bus.MCACHE_ADR_VALID_SM), 32'd1);
                chk({tag, "_adr"}, bus.MCACHE_ADR_SM, v.exp_adr);
                chk({tag, "_bsel"}, 32'(bus.MCACHE_BYTE_SEL_SM), 32'(v.exp_bsel));
                chk({tag, "_store"}, 32'(bus.MCACHE_STORE_SM), 32'(v.store));
                chk({tag, "_load"}, 32'(bus.MCACHE_LOAD_SM), 32'(v.load));
                if (v.store) chk({tag, "_sdata"}, bus.MCACHE_DATA_SM, v.exp_sdata);
                chk({tag, "_req_pop"}, 32'(bus.EXE2MEM_POP_SM), 32'(c == v.stalls));
            end
        end
        @(negedge clk);
        bus.EXE2MEM_EMPTY_SE = 1'b1;
        bus.MCACHE_STALL_SC  = 1'b0;
        #1;
        chk({tag, "_valid_clr"}, 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(bus.MCACHE_ADR_VALID_SM), 32'd0);
        chk({tag, "_adr"}, bus.MCACHE_ADR_SM, 32'd0);
        chk({tag, "_data"}, bus.MCACHE_DATA_SM, 32'd0);
        chk({tag, "_bsel"}, 32'(bus.MCACHE_BYTE_SEL_SM), 32'd0);
        chk({tag, "_store"}, 32'(bus.MCACHE_STORE_SM), 32'd0);
        chk({tag, "_load"}, 32'(bus.MCACHE_LOAD_SM), 32'd0);
        chk({tag, "_empty"}, 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);
        chk({tag, "_res"}, bus.MEM_RES_RM, 32'd0);
        chk({tag, "_dest"}, 32'(bus.MEM_DEST_RM), 32'd0);
        chk({tag, "_wb"}, 32'(bus.MEM_WB_RM), 32'd0);
        chk({tag, "_exc"}, 32'(bus.EXCEPTION_RM), 32'd0);
        chk({tag, "_pop"}, 32'(bus.EXE2MEM_POP_SM), 32'd0);
    endtask

    initial begin
        vec_t v;
        bit   seen;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.EXE2MEM_EMPTY_SE   = 1'b1;
        bus.RES_RE             = '0;
        bus.MEM_DATA_RE        = '0;
        bus.DEST_RE            = '0;
        bus.MEM_SIZE_RE        = '0;
        bus.MEM_SIGN_EXTEND_RE = 1'b0;
        bus.MEM_LOAD_RE        = 1'b0;
        bus.MEM_STORE_RE       = 1'b0;
        bus.WB_RE              = 1'b0;
        bus.EXCEPTION_RE       = 1'b0;
        bus.MCACHE_STALL_SC    = 1'b0;
        bus.MCACHE_RESULT_SC   = '0;
        bus.MEM2WBK_POP_SW     = 1'b1;

        // res, data, dest, size, sext, ld, st, wb, exc, cache, stalls,
        // acc, adr, bsel, sdata, exp_res, exp_wb, exp_exc
        vecs[0]  = '{32'h1234, 32'h0, 6'd5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h1234, 1'b1, 1'b0};
        vecs[1]  = '{32'h103, 32'h0, 6'd7, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80AABBCC, 3,
                     1'b1, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 1'b1, 1'b0};
        vecs[2]  = '{32'h202, 32'hDEADBEEF, 6'd0, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1,
                     1'b1, 32'h200, 4'b1100, 32'hBEEFBEEF, 32'h202, 1'b0, 1'b0};
        vecs[3]  = '{32'h301, 32'h0, 6'd9, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h301, 1'b0, 1'b1};
        vecs[4]  = '{32'h400, 32'h0, 6'd3, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h89ABCDEF, 0,
                     1'b1, 32'h400, 4'b1111, 32'h0, 32'h89ABCDEF, 1'b1, 1'b0};
        vecs[5]  = '{32'h502, 32'h0, 6'd4, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80017FFF, 2,
                     1'b1, 32'h500, 4'b1100, 32'h0, 32'h00008001, 1'b1, 1'b0};
        vecs[6]  = '{32'h500, 32'h0, 6'd6, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h80017FFF, 0,
                     1'b1, 32'h500, 4'b0011, 32'h0, 32'h00007FFF, 1'b1, 1'b0};
        vecs[7]  = '{32'h601, 32'h0, 6'd8, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1122F344, 1,
                     1'b1, 32'h600, 4'b0010, 32'h0, 32'h000000F3, 1'b1, 1'b0};
        vecs[8]  = '{32'h702, 32'h000000A5, 6'd10, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 2,
                     1'b1, 32'h700, 4'b0100, 32'hA5A5A5A5, 32'h702, 1'b0, 1'b0};
        vecs[9]  = '{32'h804, 32'hCAFEF00D, 6'd11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0,
                     1'b1, 32'h804, 4'b1111, 32'hCAFEF00D, 32'h804, 1'b0, 1'b0};
        vecs[10] = '{32'h902, 32'h0, 6'd13, 2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'hFFFE1234, 1,
                     1'b1, 32'h900, 4'b1100, 32'h0, 32'hFFFFFFFE, 1'b1, 1'b0};
        vecs[11] = '{32'hFFFFFFFF, 32'h0, 6'd63, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[12] = '{32'h1000, 32'h0, 6'd14, 2'b10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000007F, 0,
                     1'b1, 32'h1000, 4'b0001, 32'h0, 32'h0000007F, 1'b1, 1'b0};

        repeat (2) @(negedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("v%0d", i));
        end
        repeat (3) @(negedge clk);

        // Writeback stalled: two ALU entries fill DEPTH=2, the third waits, then wraps.
        @(negedge clk);
        bus.MEM2WBK_POP_SW = 1'b0;
        v = vecs[0];
        v.res = 32'hA1; v.dest = 6'd1; v.exp_res = 32'hA1;
        run_vec(v, "fullA");
        v.res = 32'hB2; v.dest = 6'd2; v.exp_res = 32'hB2;
        run_vec(v, "fullB");
        chk("full_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'd0);
        chk("full_head", bus.MEM_RES_RM, 32'hA1);
        @(negedge clk);
        v.res = 32'hC3; v.dest = 6'd3; v.exp_res = 32'hC3;
        drive(v);
        #1;
        chk("full_nopop0", 32'(bus.EXE2MEM_POP_SM), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("full_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
        end
        @(negedge clk);
        bus.MEM2WBK_POP_SW = 1'b1;
        #1;
        chk("full_nopop_popcycle", 32'(bus.EXE2MEM_POP_SM), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            #1;
            if (bus.EXE2MEM_POP_SM === 1'b1) seen = 1'b1;
        end
        chk("full_third_accepted", 32'(seen), 32'd1);
        @(negedge clk);
        bus.EXE2MEM_EMPTY_SE = 1'b1;
        repeat (4) @(negedge clk);

        // Reset while a load is stalled in REQ; the same head must be reissued.
        @(negedge clk);
        v = vecs[4];
        v.res = 32'hA08; v.dest = 6'd12; v.stalls = 1; v.cache = 32'h13572468;
        v.exp_res = 32'h13572468;
        drive(v);
        #1;
        chk("rst_idle_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_outputs("rst_req");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_after_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_reissue_valid", 32'(bus.MCACHE_ADR_VALID_SM), 32'd1);
        chk("rst_reissue_adr", bus.MCACHE_ADR_SM, 32'hA08);
        chk("rst_reissue_stall_nopop", 32'(bus.EXE2MEM_POP_SM), 32'd0);
        @(negedge clk);
        bus.MCACHE_STALL_SC = 1'b0;
        #1;
        chk("rst_reissue_pop", 32'(bus.EXE2MEM_POP_SM), 32'd1);
        @(negedge clk);
        bus.EXE2MEM_EMPTY_SE = 1'b1;
        repeat (4) @(negedge clk);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_empty", 32'(bus.MEM2WBK_EMPTY_SM), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Pops entries from the execute-to-memory FIFO and forwards non-memory results unchanged.
- Loads and stores go to the data cache through a valid/stall handshake. Load data is aligned and sign- or zero-extended.
- Results land in an internal memory-to-writeback FIFO, whose head also drives the bypass outputs back to execute.

Parameters:
- DEPTH, 2, mem2wbk FIFO entry count (power of two, at least 2)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- EXE2MEM_EMPTY_SE  in  1  execute FIFO empty
- EXE2MEM_POP_SM  out  1  pop execute FIFO head (combinational)
- RES_RE  in  32  ALU result / memory address
- MEM_DATA_RE  in  32  store data
- DEST_RE  in  6  destination register
- MEM_SIZE_RE  in  2  00 word, 01 half, 10 byte
- MEM_SIGN_EXTEND_RE  in  1  sign-extend load
- MEM_LOAD_RE  in  1  load
- MEM_STORE_RE  in  1  store
- WB_RE  in  1  writeback enable
- EXCEPTION_RE  in  1  entry carries an exception
- MCACHE_ADR_SM  out  32  cache address, word-aligned
- MCACHE_DATA_SM  out  32  store data, lane-replicated
- MCACHE_BYTE_SEL_SM  out  4  byte enables
- MCACHE_ADR_VALID_SM  out  1  request valid
- MCACHE_STORE_SM  out  1  request is a store
- MCACHE_LOAD_SM  out  1  request is a load
- MCACHE_STALL_SC  in  1  cache not done
- MCACHE_RESULT_SC  in  32  load word, valid when stall=0
- MEM2WBK_POP_SW  in  1  writeback pops
- MEM2WBK_EMPTY_SM  out  1  mem2wbk FIFO empty
- MEM_RES_RM  out  32  head result (also bypass)
- MEM_DEST_RM  out  6  head destination (also bypass)
- MEM_WB_RM  out  1  head writeback enable
- EXCEPTION_RM  out  1  head exception flag

Behaviour:
- Reset, asynchronous and active-high:
  - FSM goes to IDLE and the FIFO is emptied.
  - All MCACHE_* outputs are 0. MEM2WBK_EMPTY_SM is 1. MEM_RES_RM, MEM_DEST_RM, MEM_WB_RM and EXCEPTION_RM are 0.
  - An in-flight cache request is dropped with no completion.
- Definitions:
  - "head" = the execute entry visible while EXE2MEM_EMPTY_SE=0.
  - "mem op" = (MEM_LOAD_RE or MEM_STORE_RE) and not EXCEPTION_RE.
- FSM state IDLE:
  - If head is present, FIFO is not full and head is not a mem op: pop head and push {RES_RE, DEST_RE, WB_RE, EXCEPTION_RE} in the same cycle. Latency is 1 cycle.
  - If head is a mem op and FIFO is not full: register the request outputs and go to REQ. Do not pop.
  - An exception entry is pushed with wb forced to 0 and performs no cache access.
- FSM state REQ:
  - MCACHE_ADR_VALID_SM=1, with address, data, byte-select and load/store outputs held stable while MCACHE_STALL_SC=1.
  - On the first cycle with stall=0:
    - Store: pop and push {RES_RE, DEST_RE, wb=0, exc=0}.
    - Load: pop and push {formatted result, DEST_RE, WB_RE, 0}.
    - Then go to IDLE, where the ADR_VALID_SM register clears.
  - Minimum mem-op latency is 2 cycles.
- FIFO reservation: the free slot is reserved on entry to REQ, so a push from REQ never meets a full FIFO.
- Address and store formatting (off = RES_RE[1:0]):
  - Address = {RES_RE[31:2], 2'b00}.
  - Word: byte_sel 1111, data unchanged.
  - Half: byte_sel 0011 << off, data = {2{MEM_DATA_RE[15:0]}}.
  - Byte: byte_sel 0001 << off, data = {4{MEM_DATA_RE[7:0]}}.
  - Misaligned accesses never arrive; they arrive as exception entries.
- Load formatting:
  - Byte: lane MCACHE_RESULT_SC[8*off+7 : 8*off].
  - Half: lane selected by off[1].
  - Extend to 32 bits: sign-extend if MEM_SIGN_EXTEND_RE, else zero-extend.
- mem2wbk FIFO:
  - Circular buffer of DEPTH entries with wrap-around pointers and a count.
  - Outputs show the head combinationally.
  - A push while full is impossible: it is gated in IDLE.
  - A pop while empty is ignored.
  - Simultaneous push and pop keeps the count unchanged; this is legal even when full, provided the pop occurs.
  - When the FIFO becomes full, IDLE stops popping execute entries.
- EXE2MEM_POP_SM is never asserted while EXE2MEM_EMPTY_SE=1.

Test Plan:
- ALU entry RES=0x1234, DEST=5, WB=1 into an empty stage -> one cycle later MEM2WBK_EMPTY_SM=0, MEM_RES_RM=0x1234, MEM_DEST_RM=5; exactly one execute pop.
- Signed byte load, RES=0x103, cache returns 0x80AABBCC after 3 stall cycles -> address 0x100 held 3 cycles; result 0xFFFFFF80, WB=1, pop only in the completion cycle.
- Half store, RES=0x202, data 0xDEADBEEF -> byte_sel 1100, data 0xBEEFBEEF, MCACHE_STORE_SM=1; pushed with wb=0.
- Load entry with EXCEPTION_RE=1 -> ADR_VALID_SM never asserts; pushed with EXCEPTION_RM=1, MEM_WB_RM=0.
- DEPTH=2, writeback never pops, 3 ALU entries -> two accepted, third not popped until MEM2WBK_POP_SW=1; FIFO order preserved across pointer wrap-around.
- Reset asserted in REQ during a stall -> all outputs 0 immediately, EMPTY_SM=1; after release, the same execute head is reissued.
